// File: rtl/and_gate_seq_ctrl_if.sv
// Signal bundle between the AND-gate self-test sequencer and its host/gate.
// The slave side is the sequencer; the master side is the host plus the gate output.
interface and_gate_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic       gate_s;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_mask;
    logic [1:0] vec_idx;

    modport master (
        output start, abort, gate_s,
        input  gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, vec_idx
    );

    modport slave (
        input  start, abort, gate_s,
        output gate_a, gate_b, busy, done, pass, err_cnt, fail_mask, vec_idx
    );
endinterface

// File: rtl/and_gate_seq_ctrl.sv
// Self-test sequencer for a registered two-input AND gate: walks ab = 00,01,10,11,
// holds each vector DWELL cycles and checks the gate output at the end of each dwell.
module and_gate_seq_ctrl #(
    parameter int DWELL    = 5,
    parameter int GATE_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    and_gate_seq_ctrl_if.slave bus
);

    if (DWELL < 2 || DWELL > 255 || DWELL <= GATE_LAT) begin : g_param_check
        $error("and_gate_seq_ctrl: DWELL must be 2..255 and greater than GATE_LAT");
    end

    localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] vec_idx_q, vec_idx_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       gate_a_q, gate_a_d;
    logic       gate_b_q, gate_b_d;
    logic       mismatch;

    // Only four vectors exist, so the count tops out at 4; the clamp makes that explicit.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd4 : v + 3'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_idx_d   = vec_idx_q;
        err_cnt_d   = err_cnt_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gate_a_d    = gate_a_q;
        gate_b_d    = gate_b_q;
        mismatch    = bus.gate_s != (vec_idx_q[1] & vec_idx_q[0]);

        case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                if (bus.start) begin
                    state_d     = S_APPLY;
                    cnt_d       = 8'd0;
                    vec_idx_d   = 2'd0;
                    err_cnt_d   = 3'd0;
                    fail_mask_d = 4'd0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_APPLY: begin
                // Abort wins over a compare landing on the same edge.
                if (bus.abort) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                    pass_d   = 1'b0;
                end else if (cnt_q == LAST_CNT) begin
                    if (mismatch) begin
                        fail_mask_d[vec_idx_q] = 1'b1;
                        err_cnt_d              = sat_inc(err_cnt_q);
                    end
                    if (vec_idx_q == 2'd3) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        gate_a_d = 1'b0;
                        gate_b_d = 1'b0;
                        pass_d   = (err_cnt_d == 3'd0);
                    end else begin
                        vec_idx_d = vec_idx_q + 2'd1;
                        cnt_d     = 8'd0;
                        gate_a_d  = vec_idx_d[1];
                        gate_b_d  = vec_idx_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            vec_idx_q   <= 2'd0;
            err_cnt_q   <= 3'd0;
            fail_mask_q <= 4'd0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_idx_q   <= vec_idx_d;
            err_cnt_q   <= err_cnt_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gate_a_q    <= gate_a_d;
            gate_b_q    <= gate_b_d;
        end
    end

    assign bus.gate_a    = gate_a_q;
    assign bus.gate_b    = gate_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_and_gate_seq_ctrl.sv
// Bench for and_gate_seq_ctrl: behavioural gate models (AND / stuck-at-0 / OR, latency 1..3)
// feed two sequencer instances (DWELL 5 and 3); results are scoreboarded per test run.
module tb_and_gate_seq_ctrl;

    localparam int DW5 = 5;
    localparam int DW3 = 3;

    typedef struct packed {
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
    } res_t;

    logic clk;
    logic rst_n;

    and_gate_seq_ctrl_if bus5 ();
    and_gate_seq_ctrl_if bus3 ();

    and_gate_seq_ctrl #(.DWELL(DW5), .GATE_LAT(1)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
    and_gate_seq_ctrl #(.DWELL(DW3), .GATE_LAT(1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int   mode5;   // 0 = AND, 1 = stuck-at-0, 2 = OR
    int   lat5;
    logic [2:0] sr5;
    logic [2:0] sr3;
    res_t sb[$];
    int   n_pass;
    int   n_total;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic gate_fn(input int m, input logic a, input logic b);
        case (m)
            1:       return 1'b0;
            2:       return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr5 <= 3'b000;
        else        sr5 <= {sr5[1:0], gate_fn(mode5, bus5.gate_a, bus5.gate_b)};
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr3 <= 3'b000;
        else        sr3 <= {sr3[1:0], bus3.gate_a & bus3.gate_b};
    end
    assign bus5.gate_s = sr5[2'(lat5 - 1)];
    assign bus3.gate_s = sr3[2];

    // A gate slower than the sample point shows the previous vector's result (00 before vector 0).
    function automatic res_t model(input int m, input int lat, input int dw);
        res_t r;
        int   src;
        logic obs;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            src = (lat <= dw - 1) ? k : k - 1;
            obs = (src < 0) ? 1'b0 : gate_fn(m, src[1], src[0]);
            if (obs !== (k[1] & k[0])) begin
                r.mask[k] = 1'b1;
                r.err     = r.err + 3'd1;
            end
        end
        r.pass = (r.err == 3'd0);
        return r;
    endfunction

    task automatic pulse_start5;
        @(negedge clk); bus5.start = 1'b1;
        @(negedge clk); bus5.start = 1'b0;
    endtask

    task automatic wait_done5(inout int cyc);
        while (bus5.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus5.start = 1'b0; bus5.abort = 1'b0;
        bus3.start = 1'b0; bus3.abort = 1'b0;
        mode5 = 0; lat5 = 1;
        repeat (3) @(negedge clk);
        n_total++; if ({bus5.gate_a, bus5.gate_b, bus5.busy, bus5.done, bus5.pass, bus5.err_cnt, bus5.fail_mask, bus5.vec_idx} !== 14'd0)
            $display("FAIL reset_outputs5: got %b want all 0", {bus5.gate_a, bus5.gate_b, bus5.busy, bus5.done, bus5.pass, bus5.err_cnt, bus5.fail_mask, bus5.vec_idx}); else n_pass++;
        n_total++; if ({bus3.gate_a, bus3.gate_b, bus3.busy, bus3.done, bus3.pass, bus3.err_cnt, bus3.fail_mask, bus3.vec_idx} !== 14'd0)
            $display("FAIL reset_outputs3: got %b want all 0", {bus3.gate_a, bus3.gate_b, bus3.busy, bus3.done, bus3.pass, bus3.err_cnt, bus3.fail_mask, bus3.vec_idx}); else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if ({bus5.busy, bus5.done} !== 2'b00) $display("FAIL idle_after_reset: got busy/done=%b want 00", {bus5.busy, bus5.done}); else n_pass++;
    endtask

    task automatic test_correct_and;
        res_t       e;
        int         cyc;
        logic [1:0] ev;
        bit         bad;
        int         bad_cyc;
        logic [2:0] bad_got;
        mode5 = 0; lat5 = 1;
        sb.push_back(model(0, 1, DW5));
        pulse_start5();
        bad = 0; bad_cyc = 0; bad_got = '0;
        for (cyc = 0; cyc < 4 * DW5; cyc++) begin
            ev = 2'(cyc / DW5);
            if (!bad && ({bus5.gate_a, bus5.gate_b} !== ev || bus5.busy !== 1'b1 || bus5.vec_idx !== ev || bus5.done !== 1'b0)) begin
                bad = 1; bad_cyc = cyc; bad_got = {bus5.gate_a, bus5.gate_b, bus5.busy};
            end
            @(negedge clk);
        end
        n_total++; if (bad) $display("FAIL vec_seq: cycle %0d got ab,busy=%b want ab=%b busy=1", bad_cyc, bad_got, 2'(bad_cyc / DW5)); else n_pass++;
        n_total++; if (bus5.done !== 1'b1) $display("FAIL done_at_21: got done=%b want 1", bus5.done); else n_pass++;
        n_total++; if ({bus5.busy, bus5.gate_a, bus5.gate_b} !== 3'b000) $display("FAIL done_idle_pins: got %b want 000", {bus5.busy, bus5.gate_a, bus5.gate_b}); else n_pass++;
        e = sb.pop_front();
        n_total++; if ({bus5.pass, bus5.err_cnt, bus5.fail_mask} !== e) $display("FAIL and_result: got %b want %b", {bus5.pass, bus5.err_cnt, bus5.fail_mask}, e); else n_pass++;
        @(negedge clk);
        n_total++; if (bus5.done !== 1'b0) $display("FAIL done_one_cycle: got done=%b want 0", bus5.done); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (bus5.pass !== 1'b1) $display("FAIL pass_held: got %b want 1", bus5.pass); else n_pass++;
    endtask

    task automatic test_gate_faults;
        int   modes[3] = '{1, 2, 0};
        int   lats[3]  = '{1, 1, 3};
        res_t e;
        int   cyc;
        for (int i = 0; i < 3; i++) begin
            mode5 = modes[i]; lat5 = lats[i];
            sb.push_back(model(modes[i], lats[i], DW5));
            pulse_start5();
            cyc = 0;
            wait_done5(cyc);
            n_total++; if (cyc !== 4 * DW5) $display("FAIL fault%0d_done_time: got %0d want %0d", i, cyc, 4 * DW5); else n_pass++;
            e = sb.pop_front();
            n_total++; if (bus5.fail_mask !== e.mask) $display("FAIL fault%0d_mask: got %b want %b", i, bus5.fail_mask, e.mask); else n_pass++;
            n_total++; if (bus5.err_cnt !== e.err) $display("FAIL fault%0d_err: got %0d want %0d", i, bus5.err_cnt, e.err); else n_pass++;
            n_total++; if (bus5.pass !== e.pass) $display("FAIL fault%0d_pass: got %b want %b", i, bus5.pass, e.pass); else n_pass++;
            @(negedge clk);
        end
        mode5 = 0; lat5 = 1;
    endtask

    task automatic test_latency_violation;
        res_t e;
        int   cyc;
        sb.push_back(model(0, 3, DW3));
        @(negedge clk); bus3.start = 1'b1;
        @(negedge clk); bus3.start = 1'b0;
        cyc = 0;
        while (bus3.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (cyc !== 4 * DW3) $display("FAIL lat3_done_time: got %0d want %0d", cyc, 4 * DW3); else n_pass++;
        e = sb.pop_front();
        n_total++; if ({bus3.pass, bus3.err_cnt, bus3.fail_mask} !== e) $display("FAIL lat3_result: got %b want %b", {bus3.pass, bus3.err_cnt, bus3.fail_mask}, e); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort;
        res_t e;
        int   cyc;
        bit   saw_done;
        mode5 = 2; lat5 = 1;
        pulse_start5();
        repeat (2 * DW5 + 2) @(negedge clk);
        n_total++; if (bus5.vec_idx !== 2'd2) $display("FAIL abort_in_vec2: got vec_idx=%0d want 2", bus5.vec_idx); else n_pass++;
        bus5.abort = 1'b1;
        @(negedge clk); bus5.abort = 1'b0;
        n_total++; if ({bus5.gate_a, bus5.gate_b, bus5.busy, bus5.pass} !== 4'b0000) $display("FAIL abort_pins: got ab,busy,pass=%b want 0000", {bus5.gate_a, bus5.gate_b, bus5.busy, bus5.pass}); else n_pass++;
        n_total++; if ({bus5.err_cnt, bus5.fail_mask} !== {3'd1, 4'b0010}) $display("FAIL abort_partial: got err,mask=%b want 0010010", {bus5.err_cnt, bus5.fail_mask}); else n_pass++;
        saw_done = 0;
        repeat (30) begin @(negedge clk); if (bus5.done === 1'b1) saw_done = 1; end
        n_total++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got done pulse want none"); else n_pass++;

        // Abort landing exactly on vector 1's compare edge discards that compare.
        pulse_start5();
        repeat (2 * DW5 - 1) @(negedge clk);
        bus5.abort = 1'b1;
        @(negedge clk); bus5.abort = 1'b0;
        n_total++; if ({bus5.busy, bus5.err_cnt, bus5.fail_mask} !== 8'd0) $display("FAIL abort_priority: got busy,err,mask=%b want 0", {bus5.busy, bus5.err_cnt, bus5.fail_mask}); else n_pass++;

        mode5 = 0;
        sb.push_back(model(0, 1, DW5));
        pulse_start5();
        cyc = 0;
        wait_done5(cyc);
        e = sb.pop_front();
        n_total++; if (cyc !== 4 * DW5) $display("FAIL rerun_done_time: got %0d want %0d", cyc, 4 * DW5); else n_pass++;
        n_total++; if ({bus5.pass, bus5.err_cnt, bus5.fail_mask} !== e) $display("FAIL rerun_result: got %b want %b", {bus5.pass, bus5.err_cnt, bus5.fail_mask}, e); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_restart_ignored;
        res_t e;
        int   cyc;
        mode5 = 0; lat5 = 1;
        sb.push_back(model(0, 1, DW5));
        pulse_start5();
        repeat (7) @(negedge clk);
        bus5.start = 1'b1;
        @(negedge clk); bus5.start = 1'b0;
        cyc = 8;
        wait_done5(cyc);
        e = sb.pop_front();
        n_total++; if (cyc !== 4 * DW5) $display("FAIL restart_done_time: got %0d want %0d", cyc, 4 * DW5); else n_pass++;
        n_total++; if ({bus5.pass, bus5.err_cnt, bus5.fail_mask} !== e) $display("FAIL restart_result: got %b want %b", {bus5.pass, bus5.err_cnt, bus5.fail_mask}, e); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        res_t e;
        int   cyc;
        mode5 = 0; lat5 = 1;
        sb.push_back(model(0, 1, DW5));
        sb.push_back(model(1, 1, DW5));
        pulse_start5();
        cyc = 0;
        wait_done5(cyc);
        e = sb.pop_front();
        n_total++; if ({bus5.pass, bus5.err_cnt, bus5.fail_mask} !== e) $display("FAIL b2b_first: got %b want %b", {bus5.pass, bus5.err_cnt, bus5.fail_mask}, e); else n_pass++;
        bus5.start = 1'b1;
        mode5 = 1;
        @(negedge clk);
        n_total++; if ({bus5.busy, bus5.pass} !== 2'b01) $display("FAIL b2b_start_in_done: got busy,pass=%b want 01", {bus5.busy, bus5.pass}); else n_pass++;
        @(negedge clk); bus5.start = 1'b0;
        n_total++; if ({bus5.busy, bus5.pass} !== 2'b10) $display("FAIL b2b_accept: got busy,pass=%b want 10", {bus5.busy, bus5.pass}); else n_pass++;
        cyc = 0;
        wait_done5(cyc);
        e = sb.pop_front();
        n_total++; if (cyc !== 4 * DW5) $display("FAIL b2b_done_time: got %0d want %0d", cyc, 4 * DW5); else n_pass++;
        n_total++; if ({bus5.pass, bus5.err_cnt, bus5.fail_mask} !== e) $display("FAIL b2b_second: got %b want %b", {bus5.pass, bus5.err_cnt, bus5.fail_mask}, e); else n_pass++;
        mode5 = 0;
        @(negedge clk);
    endtask

    task automatic test_start_abort_idle;
        res_t e;
        int   cyc;
        mode5 = 0; lat5 = 1;
        sb.push_back(model(0, 1, DW5));
        @(negedge clk); bus5.start = 1'b1; bus5.abort = 1'b1;
        @(negedge clk); bus5.start = 1'b0; bus5.abort = 1'b0;
        n_total++; if (bus5.busy !== 1'b1) $display("FAIL start_abort_idle: got busy=%b want 1", bus5.busy); else n_pass++;
        cyc = 0;
        wait_done5(cyc);
        e = sb.pop_front();
        n_total++; if ({bus5.pass, bus5.err_cnt, bus5.fail_mask} !== e) $display("FAIL start_abort_result: got %b want %b", {bus5.pass, bus5.err_cnt, bus5.fail_mask}, e); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        mode5 = 2; lat5 = 1;
        pulse_start5();
        repeat (2 * DW5 + 2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_total++; if ({bus5.gate_a, bus5.gate_b, bus5.busy, bus5.done, bus5.pass, bus5.err_cnt, bus5.fail_mask, bus5.vec_idx} !== 14'd0)
            $display("FAIL reset_mid_async: got %b want all 0", {bus5.gate_a, bus5.gate_b, bus5.busy, bus5.done, bus5.pass, bus5.err_cnt, bus5.fail_mask, bus5.vec_idx}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        saw_done = 0;
        repeat (30) begin @(negedge clk); if (bus5.done === 1'b1 || bus5.busy === 1'b1) saw_done = 1; end
        n_total++; if (saw_done !== 1'b0) $display("FAIL reset_mid_quiet: got activity after reset want none"); else n_pass++;
        mode5 = 0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        test_reset();
        test_correct_and();
        test_gate_faults();
        test_latency_violation();
        test_abort();
        test_restart_ignored();
        test_back_to_back();
        test_start_abort_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/and_gate_seq_ctrl.md
# and_gate_seq_ctrl

Self-test sequencer for the registered two-input AND gate block. On a start pulse it drives the gate's `a`/`b` inputs through all four input combinations, holds each for a programmable dwell, and samples the gate's registered output `s`. It compares each sample against the expected AND value and reports a per-vector fail mask, an error count and a pass flag. It sits beside the gate instance, owns the gate's input pins during a test, and returns them to 0 when idle.

## Interface
Parameters:
- `DWELL`, default 5: cycles each vector is held. Legal range 2..255. Must be greater than `GATE_LAT`.
- `GATE_LAT`, default 1: register latency of the gate under test, in cycles. Informational; elaboration fails if `DWELL <= GATE_LAT`.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: begin a test. Sampled only in IDLE.
- `abort`, in, 1: synchronous abort of a running test.
- `gate_s`, in, 1: registered output of the gate under test.
- `gate_a`, out, 1: drives the gate's `a` input.
- `gate_b`, out, 1: drives the gate's `b` input.
- `busy`, out, 1: high while a test is running.
- `done`, out, 1: one-cycle pulse when a test completes normally.
- `pass`, out, 1: 1 when the last completed test had no mismatches. Held until the next start.
- `err_cnt`, out, 3: number of mismatching vectors in the current or last test (0..4).
- `fail_mask`, out, 4: bit k is set when vector k mismatched.
- `vec_idx`, out, 2: index of the vector currently applied.

## Operation
- Vector k encoding: `gate_a` = k[1], `gate_b` = k[0]. Order is 0, 1, 2, 3 (ab = 00, 01, 10, 11). Expected `gate_s` = k[1] & k[0].
- FSM states: IDLE, APPLY, DONE.
  - IDLE:
    - `gate_a`, `gate_b` and `busy` are 0.
    - When `start` = 1: clear `err_cnt`, `fail_mask`, `pass`, `vec_idx` and the dwell counter, then go to APPLY.
  - APPLY:
    - `busy` = 1. `gate_a`/`gate_b` are driven from `vec_idx`.
    - The dwell counter runs 0..DWELL-1.
    - At count DWELL-1, compare `gate_s` against the expected value. On mismatch, set `fail_mask[vec_idx]` and increment `err_cnt`.
    - Then: if `vec_idx` < 3, increment `vec_idx` and clear the counter. If `vec_idx` = 3, go to DONE.
  - DONE (one cycle):
    - `done` = 1, `busy` = 0, `gate_a` = `gate_b` = 0.
    - `pass` is registered as (`err_cnt` == 0 including the final compare).
    - Return to IDLE.
- `abort` = 1 in APPLY:
  - Next state is IDLE. `gate_a`/`gate_b` go to 0.
  - No `done` pulse. `pass` = 0.
  - `err_cnt`/`fail_mask` keep their partial values.
- `abort` has priority over a compare occurring in the same cycle: that compare is discarded.
- `start` during APPLY or DONE is ignored. It is not queued.
- `start` and `abort` high together in IDLE: start wins, because abort has no effect in IDLE.
- `err_cnt` saturates at 4 by construction and never wraps.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs are 0: `gate_a`, `gate_b`, `busy`, `done`, `pass`, `err_cnt`, `fail_mask`, `vec_idx`.
- All outputs are registered.
- Reset asserted mid-test: immediate return to reset values. The gate's inputs drop to 0 asynchronously.
- Start at cycle t0 (start high at edge t0):
  - `busy` rises and vector 0 appears at t0+1.
  - Vector k is applied during cycles t0+1+k·DWELL through t0+(k+1)·DWELL.
  - `gate_s` for vector k is sampled at the edge ending cycle t0+(k+1)·DWELL. That is DWELL-1 ≥ GATE_LAT cycles after the inputs change.
  - `done` is high and `busy` is low during cycle t0+4·DWELL+1. `pass` is valid from then on.
- Total test length is 4·DWELL+1 cycles. With DWELL = 5: 21 cycles, 420 ns.
- Back-to-back operation: the earliest next accepted start is the cycle after DONE, since IDLE must be reached first.

## Test plan
- Correct gate (behavioural registered AND, latency 1), DWELL = 5, start pulse at 200 ns:
  - `gate_a`/`gate_b` step 00, 01, 10, 11 every 100 ns.
  - `done` pulses one cycle at start + 21 cycles.
  - `pass` = 1, `err_cnt` = 0, `fail_mask` = 0000.
- Gate stuck-at-0:
  - Only vector 3 fails: `fail_mask` = 1000, `err_cnt` = 1, `pass` = 0.
- Gate replaced by OR:
  - Vectors 1 and 2 fail: `fail_mask` = 0110, `err_cnt` = 2, `pass` = 0.
- Gate latency 3 with DWELL = 3:
  - Stale samples cause mismatches. `fail_mask` = 1000 for a correct AND, so the bench flags the latency violation.
  - Repeat with DWELL = 5: `pass` = 1.
- `abort` asserted during vector 2:
  - `gate_a`/`gate_b` are 0 on the next cycle. `busy` = 0. No `done`. `pass` = 0.
  - A following start gives a full clean run with `pass` = 1.
- `start` re-pulsed mid-test is ignored, and `done` timing is unchanged.
- `rst_n` pulsed low mid-test: all outputs read 0 asynchronously while reset is low. No `done` follows.
